mem_port_arbiter: RTL and testbench

Sequences and shares one single-ported unified instruction/data memory among three requesters: instruction fetch (IF), the MEM-stage data access, and an external program loader (LD). It replaces the dual-port memory hookup with a request/ready handshake on each side, and exposes a stall to the pipeline. Arbitration is fixed priority, with an optional fetch anti-starvation guard. Data returns registered.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory among program loader, data port and fetch (LD > DM > IF).
// Defining MEM_ARB_STARVE_GUARD_EN adds a guard that forces a fetch grant after STARVE_LIMIT non-fetch grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              cpu_stall
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {G_IF, G_DM, G_LD} grant_t;

    state_t            state_q, state_d;
    grant_t            grant_q, grant_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              ld_ready_q, ld_ready_d;

    logic   arb_en, elig_if, elig_dm, elig_ld, force_if, grant_valid;
    grant_t arb_sel;

    // The requester being acknowledged in RESP still has req high; it must not be re-granted.
    assign arb_en  = (state_q == IDLE) || (state_q == RESP);
    assign elig_if = if_req && !((state_q == RESP) && (grant_q == G_IF));
    assign elig_dm = dm_req && !((state_q == RESP) && (grant_q == G_DM));
    assign elig_ld = ld_req && !((state_q == RESP) && (grant_q == G_LD));

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_if = elig_if && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb_en && grant_valid) begin
            if (arb_sel == G_IF)
                starve_cnt_d = '0;
            else if (if_req && (starve_cnt_q != CNT_W'(STARVE_LIMIT)))
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign force_if = 1'b0;
`endif

    always_comb begin
        grant_valid = 1'b1;
        arb_sel     = G_IF;
        if (force_if)     arb_sel = G_IF;
        else if (elig_ld) arb_sel = G_LD;
        else if (elig_dm) arb_sel = G_DM;
        else if (elig_if) arb_sel = G_IF;
        else              grant_valid = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        ld_ready_d  = 1'b0;
        case (state_q)
            ACCESS: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    case (grant_q)
                        G_IF: begin
                            if_ready_d = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
                        G_DM: begin
                            dm_ready_d = 1'b1;
                            if (!mem_we_q) dm_rdata_d = mem_rdata;
                        end
                        default: ld_ready_d = 1'b1;
                    endcase
                end
            end
            default: begin
                if (grant_valid) begin
                    state_d   = ACCESS;
                    grant_d   = arb_sel;
                    mem_req_d = 1'b1;
                    case (arb_sel)
                        G_LD: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ld_addr;
                            mem_wdata_d = ld_wdata;
                        end
                        G_DM: begin
                            mem_we_d    = dm_we;
                            mem_addr_d  = dm_addr;
                            mem_wdata_d = dm_wdata;
                        end
                        default: begin
                            mem_we_d   = 1'b0;
                            mem_addr_d = if_addr;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= G_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            ld_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign ld_ready  = ld_ready_q;
    assign cpu_stall = (if_req && !if_ready_q) || (dm_req && !dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory that answers after wait_states cycles.
// Build with MEM_ARB_STARVE_GUARD_EN defined to exercise the fetch anti-starvation guard.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [11:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        ld_req = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [31:0] ld_wdata = '0;
    logic        ld_ready;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        cpu_stall;

    int n_checks = 0;
    int n_pass   = 0;
    int wait_states = 0;
    int acc_cnt = 0;
    logic [31:0] mem_array [0:4095];

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    // Memory answers on the wait_states-th cycle of mem_req; store cycles return junk read data.
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            acc_cnt   = 0;
            mem_ready = 1'b0;
        end else begin
            if (acc_cnt == wait_states) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem_rdata = 32'hBAD0BAD0;
                    mem_array[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = mem_array[mem_addr];
                end
            end else begin
                mem_ready = 1'b0;
            end
            acc_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if ({mem_req, mem_we, if_ready, dm_ready, ld_ready, cpu_stall} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, if_ready, dm_ready, ld_ready, cpu_stall});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0)
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h dm_rdata=%h want all 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
        else n_pass++;
        reset = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single_fetch();
        if_addr = 12'h004;
        if_req  = 1'b1;
        step();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, if_ready} !== {1'b1, 1'b0, 12'h004, 1'b0})
            $display("FAIL fetch_access: req=%b we=%b addr=%h rdy=%b want 1 0 004 0", mem_req, mem_we, mem_addr, if_ready);
        else n_pass++;
        step();
        n_checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h2008000A || cpu_stall !== 1'b0)
            $display("FAIL fetch_resp: rdy=%b rdata=%h stall=%b want 1 2008000a 0", if_ready, if_rdata, cpu_stall);
        else n_pass++;
        if_req = 1'b0;
        step();
        n_checks++;
        if (if_ready !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h2008000A)
            $display("FAIL fetch_pulse: rdy=%b mem_req=%b rdata=%h want 0 0 2008000a", if_ready, mem_req, if_rdata);
        else n_pass++;
        $display("test_single_fetch done");
    endtask

    task automatic test_contention();
        int ld_t, dm_t, if_t;
        logic [11:0] a1, a3, a5;
        logic we1;
        ld_t = -1; dm_t = -1; if_t = -1;
        a1 = '0; a3 = '0; a5 = '0; we1 = 1'b0;
        ld_addr = 12'h010; ld_wdata = 32'hDEADBEEF; ld_req = 1'b1;
        dm_addr = 12'h100; dm_we = 1'b0; dm_req = 1'b1;
        if_addr = 12'h008; if_req = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t == 1) begin a1 = mem_addr; we1 = mem_we; end
            if (t == 3) a3 = mem_addr;
            if (t == 5) a5 = mem_addr;
            if (ld_ready && ld_t < 0) begin ld_t = t; ld_req = 1'b0; end
            if (dm_ready && dm_t < 0) begin dm_t = t; dm_req = 1'b0; end
            if (if_ready && if_t < 0) begin if_t = t; if_req = 1'b0; end
        end
        n_checks++;
        if (ld_t != 2 || dm_t != 4 || if_t != 6)
            $display("FAIL contention_timing: ld=%0d dm=%0d if=%0d want 2 4 6", ld_t, dm_t, if_t);
        else n_pass++;
        n_checks++;
        if (a1 !== 12'h010 || we1 !== 1'b1 || a3 !== 12'h100 || a5 !== 12'h008)
            $display("FAIL contention_order: addr %h/%h/%h we1=%b want 010/100/008 we1=1", a1, a3, a5, we1);
        else n_pass++;
        n_checks++;
        if (dm_rdata !== 32'hCAFEF00D || if_rdata !== 32'h11112222 || mem_array[12'h010] !== 32'hDEADBEEF)
            $display("FAIL contention_data: dm=%h if=%h mem[010]=%h want cafef00d 11112222 deadbeef",
                     dm_rdata, if_rdata, mem_array[12'h010]);
        else n_pass++;
        $display("test_contention done");
    endtask

    task automatic test_wait_states();
        int bad;
        bad = 0;
        wait_states = 3;
        dm_addr = 12'h0FF; dm_wdata = 32'h12345678; dm_we = 1'b1; dm_req = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            step();
            if ({mem_req, mem_we, mem_addr, mem_wdata, dm_ready} !== {1'b1, 1'b1, 12'h0FF, 32'h12345678, 1'b0})
                bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL wait_hold: %0d bad access cycles want 0", bad);
        else n_pass++;
        step();
        n_checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'hCAFEF00D || mem_array[12'h0FF] !== 32'h12345678)
            $display("FAIL wait_resp: rdy=%b rdata=%h mem[0ff]=%h want 1 cafef00d 12345678",
                     dm_ready, dm_rdata, mem_array[12'h0FF]);
        else n_pass++;
        dm_req = 1'b0; dm_we = 1'b0;
        wait_states = 0;
        step();
        $display("test_wait_states done");
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        wait_states = 2;
        dm_addr = 12'h020; dm_we = 1'b0; dm_req = 1'b1;
        #1;
        n_checks++;
        if (cpu_stall !== 1'b1) $display("FAIL stall_req_cycle: got %b want 1", cpu_stall);
        else n_pass++;
        for (int t = 1; t <= 4; t++) begin
            step();
            if (cpu_stall !== (t < 4) || dm_ready !== (t == 4)) bad++;
        end
        n_checks++;
        if (bad != 0 || dm_rdata !== 32'h0BADF00D)
            $display("FAIL stall_profile: %0d bad cycles rdata=%h want 0 0badf00d", bad, dm_rdata);
        else n_pass++;
        dm_req = 1'b0;
        wait_states = 0;
        step();
        $display("test_stall done");
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        pulses = 0;
        wait_states = 10;
        if_addr = 12'h004; if_req = 1'b1;
        step();
        step();
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL rst_mid_pre: mem_req=%b want 1", mem_req);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, if_ready, mem_addr, if_rdata} !== '0)
            $display("FAIL rst_mid_async: req=%b rdy=%b addr=%h rdata=%h want 0", mem_req, if_ready, mem_addr, if_rdata);
        else n_pass++;
        if_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        wait_states = 0;
        for (int t = 1; t <= 5; t++) begin
            step();
            if (if_ready || dm_ready || ld_ready || mem_req) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL rst_mid_quiet: %0d active cycles want 0", pulses);
        else n_pass++;
        if_req = 1'b1;
        step();
        step();
        n_checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h2008000A)
            $display("FAIL rst_mid_recover: rdy=%b rdata=%h want 1 2008000a", if_ready, if_rdata);
        else n_pass++;
        if_req = 1'b0;
        step();
        $display("test_reset_mid_access done");
    endtask

    task automatic test_starvation();
        int nf, if_first_nf, exp_nf;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_nf = 4;
`else
        exp_nf = 11;
`endif
        nf = 0; if_first_nf = -1;
        ld_addr = 12'h040; ld_wdata = 32'h0000_5A5A; ld_req = 1'b1;
        dm_addr = 12'h030; dm_we = 1'b0; dm_req = 1'b1;
        if_addr = 12'h004; if_req = 1'b1;
        for (int t = 1; t <= 60 && (ld_req || dm_req || if_req); t++) begin
            step();
            if (if_ready) begin
                if (if_first_nf < 0) if_first_nf = nf;
                if_req = 1'b0;
            end
            if (ld_ready) begin nf++; if (t >= 20) ld_req = 1'b0; end
            if (dm_ready) begin nf++; if (t >= 20) dm_req = 1'b0; end
        end
        n_checks++;
        if ({ld_req, dm_req, if_req} !== 3'b000)
            $display("FAIL starve_timeout: reqs still pending %b want 000", {ld_req, dm_req, if_req});
        else n_pass++;
        n_checks++;
        if (if_first_nf != exp_nf)
            $display("FAIL starve_grants: non-fetch grants before fetch %0d want %0d", if_first_nf, exp_nf);
        else n_pass++;
        n_checks++;
        if (if_rdata !== 32'h2008000A) $display("FAIL starve_rdata: got %h want 2008000a", if_rdata);
        else n_pass++;
        step();
        $display("test_starvation done");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_array[i] = '0;
        mem_array[12'h004] = 32'h2008000A;
        mem_array[12'h008] = 32'h11112222;
        mem_array[12'h100] = 32'hCAFEF00D;
        mem_array[12'h020] = 32'h0BADF00D;
        test_reset();
        test_single_fetch();
        test_contention();
        test_wait_states();
        test_stall();
        test_reset_mid_access();
        test_starvation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
